// File: rtl/alu_mult_sequencer_if.sv
// Bus between the multiply sequencer and its surroundings: the start/operand
// request, the shared-ALU req/gnt handshake with its operand and result
// lines, and the status and product outputs.
interface alu_mult_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic             alu_req;
   logic             alu_gnt;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // Sequencer side
   modport slave (
      input  start, mcand, mplier, alu_gnt, alu_result, alu_carry,
      output alu_req, alu_a, alu_b, alu_ctrl, busy, done, hi, lo
   );

   // Pipeline / arbiter / ALU side
   modport master (
      output start, mcand, mplier, alu_gnt, alu_result, alu_carry,
      input  alu_req, alu_a, alu_b, alu_ctrl, busy, done, hi, lo
   );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Unsigned WIDTHxWIDTH -> 2*WIDTH multiply by shift-add, borrowing the
// shared ALU for one add per step. HI accumulates the partial product while
// LO shifts the multiplier out and the product's low bits in. A step only
// commits on an edge where the arbiter grants the ALU; otherwise it stalls.
module alu_mult_sequencer #(
   parameter int         WIDTH   = 32,
   parameter logic [1:0] ALU_ADD = 2'b00,
   parameter int         CNT_W   = 6
) (
   input logic                clk,
   input logic                reset,
   alu_mult_sequencer_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_mcand;
   logic [CNT_W-1:0] r_count;
   logic             r_busy;
   logic             r_done;
   logic             r_req;
   logic             w_step;

   // A step happens only when we are asking for the ALU and got it
   assign w_step = r_req && bus.alu_gnt;

   // ALU operands come straight from the registers: add mcand only when the
   // multiplier bit currently at LO[0] is set, otherwise add zero (pure shift)
   assign bus.alu_a    = r_hi;
   assign bus.alu_b    = r_lo[0] ? r_mcand : '0;
   assign bus.alu_ctrl = ALU_ADD;
   assign bus.alu_req  = r_req;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;

   // Control FSM and datapath; outputs are registered alongside the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_hi    <= '0;
         r_lo    <= '0;
         r_mcand <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_req   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand <= bus.mcand;
                  r_lo    <= bus.mplier;
                  r_hi    <= '0;
                  r_count <= '0;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_step) begin
                  // {carry,sum,lo} shifted right by one
                  r_hi    <= {bus.alu_carry, bus.alu_result[WIDTH-1:1]};
                  r_lo    <= {bus.alu_result[0], r_lo[WIDTH-1:1]};
                  r_count <= r_count + CNT_W'(1);
                  if (r_count == LAST_STEP) begin
                     r_req   <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_req   <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: an ideal combinational ALU, an abstract
// model of the partially formed product, a per-cycle compare process and
// directed multiplies with hand-computed products and latencies.
module tb_alu_mult_sequencer;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   alu_mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_mult_sequencer #(.WIDTH(WIDTH), .ALU_ADD(2'b00), .CNT_W(6)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared ALU doing the add it is asked for
   assign {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // After k multiplier bits have been consumed, the product register holds
   // mcand*(low k bits of mplier) in its top 32+k bits and the unconsumed
   // multiplier bits in its bottom 32-k bits.
   function automatic logic [63:0] partial(input logic [31:0] mc, input logic [31:0] mp, input int k);
      logic [63:0] mask;
      mask = (64'd1 << k) - 64'd1;
      return ((64'(mc) * (64'(mp) & mask)) << (WIDTH - k)) | (64'(mp) >> k);
   endfunction

   // Model: phase 0 idle, 1 multiplying, 2 finished; k = bits consumed
   int          m_ph   = 0;
   int          m_k    = 0;
   logic [31:0] m_mc   = '0;
   logic [31:0] m_mp   = '0;
   logic [63:0] m_prod = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ph <= 0; m_k <= 0; m_mc <= '0; m_mp <= '0; m_prod <= '0;
      end else if (m_ph == 0) begin
         if (bus.start) begin
            m_ph <= 1; m_k <= 0; m_mc <= bus.mcand; m_mp <= bus.mplier;
            m_prod <= {32'd0, bus.mplier};
         end
      end else if (m_ph == 1) begin
         if (bus.alu_gnt) begin
            m_k    <= m_k + 1;
            m_prod <= partial(m_mc, m_mp, m_k + 1);
            if (m_k + 1 == WIDTH) m_ph <= 2;
         end
      end else begin
         m_ph <= 0;
      end
   end

   // Every cycle: DUT outputs against the model
   always @(negedge clk) begin
      chk("busy",     bus.busy,    64'(m_ph != 0));
      chk("done",     bus.done,    64'(m_ph == 2));
      chk("alu_req",  bus.alu_req, 64'(m_ph == 1));
      chk("hi",       bus.hi,      m_prod[63:32]);
      chk("lo",       bus.lo,      m_prod[31:0]);
      chk("alu_a",    bus.alu_a,   m_prod[63:32]);
      chk("alu_b",    bus.alu_b,   m_prod[0] ? m_mc : 32'd0);
      chk("alu_ctrl", bus.alu_ctrl, 2'b00);
   end

   // One multiply, entered at a negedge with the DUT idle
   task automatic run_mul(input logic [31:0] mc, input logic [31:0] mp, input int nstall,
                          input bit rerun, input bit in_done,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat);
      int c0, steps, stalls, nbusy;
      bit got;
      bus.start = 1'b1; bus.mcand = mc; bus.mplier = mp; bus.alu_gnt = 1'b1;
      c0 = cyc + 1; steps = 0; stalls = nstall; nbusy = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            got = 1'b1;
            chk("latency", 64'(cyc - c0 + 1), 64'(elat));
            chk("prod_hi", bus.hi, ehi);
            chk("prod_lo", bus.lo, elo);
            if (in_done) begin
               bus.start = 1'b1; bus.mcand = 32'hA5A5A5A5; bus.mplier = 32'h5A5A5A5A;
            end
         end else begin
            if (rerun && steps == 5) begin
               bus.start = 1'b1; bus.mcand = ~mc; bus.mplier = ~mp;
            end
            if (stalls > 0 && (steps == WIDTH - 1 || $urandom_range(0, 1) == 0)) begin
               bus.alu_gnt = 1'b0; stalls--;
            end else begin
               bus.alu_gnt = 1'b1; steps++;
            end
         end
      end
      if (!got) chk("done_timeout", 64'd0, 64'd1);
      chk("busy_cycles", 64'(nbusy), 64'(elat));
      @(negedge clk);
      bus.start = 1'b0;
      chk("idle_busy", bus.busy, 64'd0);
      chk("hold_hi", bus.hi, ehi);
      chk("hold_lo", bus.lo, elo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.mcand = '0; bus.mplier = '0; bus.alu_gnt = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hi",   bus.hi,      64'd0);
      chk("rst_lo",   bus.lo,      64'd0);
      chk("rst_busy", bus.busy,    64'd0);
      chk("rst_done", bus.done,    64'd0);
      chk("rst_req",  bus.alu_req, 64'd0);
      chk("rst_a",    bus.alu_a,   64'd0);
      chk("rst_b",    bus.alu_b,   64'd0);
      #2 reset = 1'b0;
      @(negedge clk);

      // Literals pinning the model's partial-product view
      chk("model_3x5",  partial(32'd3, 32'd5, 32), 64'h0000_0000_0000_000F);
      chk("model_ff",   partial(32'hFFFFFFFF, 32'hFFFFFFFF, 32), 64'hFFFF_FFFE_0000_0001);
      chk("model_k0",   partial(32'd3, 32'd5, 0), 64'h0000_0000_0000_0005);

      run_mul(32'd3,          32'd5,          0,  1'b0, 1'b0, 32'h00000000, 32'h0000000F, 33);
      run_mul(32'hFFFFFFFF,   32'hFFFFFFFF,   0,  1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33);
      run_mul(32'h12345678,   32'd0,          0,  1'b0, 1'b0, 32'h00000000, 32'h00000000, 33);
      run_mul(32'h80000000,   32'd2,          0,  1'b0, 1'b0, 32'h00000001, 32'h00000000, 33);
      run_mul(32'd7,          32'd9,          10, 1'b0, 1'b0, 32'h00000000, 32'h0000003F, 43);
      run_mul(32'h00012345,   32'h00000100,   0,  1'b1, 1'b1, 32'h00000000, 32'h01234500, 33);

      // Abort a multiply part-way through with an asynchronous reset
      bus.start = 1'b1; bus.mcand = 32'hDEADBEEF; bus.mplier = 32'h01234567; bus.alu_gnt = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("pre_abort_busy", bus.busy, 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("abort_hi",   bus.hi,      64'd0);
      chk("abort_lo",   bus.lo,      64'd0);
      chk("abort_busy", bus.busy,    64'd0);
      chk("abort_done", bus.done,    64'd0);
      chk("abort_req",  bus.alu_req, 64'd0);
      chk("abort_a",    bus.alu_a,   64'd0);
      chk("abort_b",    bus.alu_b,   64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      run_mul(32'd6, 32'd7, 0, 1'b0, 1'b0, 32'h00000000, 32'h0000002A, 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
